qarctan_two_input: RTL and testbench

Quantized two-input arctangent for the FM demodulator datapath. Each cycle it may pop one y sample from FIFO A and one x sample from FIFO B, compute a 10-bit-fraction fixed-point approximation of atan2(y, x) with a serial divider, and push the 32-bit signed angle into an output FIFO. All three FIFOs are show-ahead (first-word-fall-through) `fifo` instances. `dout` is valid whenever `empty` is low, and `rd_en` pops the word at the next clock edge.

---
 rtl/qarctan_two_input.sv | 139 +++++++++++++
 tb/tb_qarctan_two_input.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/qarctan_two_input.sv
// Quantized atan2(y, x) with 10-bit fraction: pops one y/x pair, divides serially over
// 32 cycles, then pushes the signed angle to the output FIFO.
module qarctan_two_input (
   input  logic        clock,
   input  logic        reset,
   output logic        inA_rd_en,
   input  logic        inA_empty,
   input  logic [31:0] inA_dout,
   output logic        inB_rd_en,
   input  logic        inB_empty,
   input  logic [31:0] inB_dout,
   output logic        out_wr_en,
   input  logic        out_full,
   output logic [31:0] out_din
);

   localparam logic signed [31:0] QUAD1 = 32'sd804;
   localparam logic signed [31:0] QUAD3 = 32'sd2412;
   localparam int unsigned        BITS  = 10;

   typedef enum logic [1:0] {StRead, StDiv, StCalc, StWrite} state_e;

   state_e      state_q, state_d;
   logic        y_neg_q, y_neg_d;
   logic        x_neg_q, x_neg_d;
   logic        num_neg_q, num_neg_d;
   logic [31:0] den_q, den_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] out_din_q, out_din_d;

   logic               pop;
   logic signed [31:0] y_in, x_in, ay, num, den;
   logic [32:0]        trial;
   logic signed [31:0] r, p, p_adj, d, angle;

   // Both FIFOs are popped together or not at all.
   assign pop       = reset && (state_q == StRead) && !inA_empty && !inB_empty;
   assign inA_rd_en = pop;
   assign inB_rd_en = pop;
   assign out_wr_en = (state_q == StWrite) && !out_full;
   assign out_din   = out_din_q;

   // Divider setup straight from the FIFO heads so DIV can start the next cycle.
   always_comb begin
      y_in = inA_dout;
      x_in = inB_dout;
      ay   = (y_in[31] ? -y_in : y_in) + 32'sd1;
      if (!x_in[31]) begin
         num = (x_in - ay) <<< BITS;
         den = x_in + ay;
      end else begin
         num = (x_in + ay) <<< BITS;
         den = ay - x_in;
      end
   end

   always_comb begin
      trial = {rem_q, quo_q[31]} - {1'b0, den_q};
      r     = num_neg_q ? -$signed(quo_q) : $signed(quo_q);
      p     = QUAD1 * r;
      // Bias negative products so the arithmetic shift truncates toward zero.
      p_adj = p + (p[31] ? 32'sd1023 : 32'sd0);
      d     = p_adj >>> BITS;
      angle = (x_neg_q ? QUAD3 : QUAD1) - d;
      if (y_neg_q) angle = -angle;
   end

   always_comb begin
      state_d   = state_q;
      y_neg_d   = y_neg_q;
      x_neg_d   = x_neg_q;
      num_neg_d = num_neg_q;
      den_d     = den_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      out_din_d = out_din_q;
      unique case (state_q)
         StRead: begin
            if (pop) begin
               y_neg_d   = y_in[31];
               x_neg_d   = x_in[31];
               num_neg_d = num[31];
               quo_d     = num[31] ? -num : num;
               den_d     = den;
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = StDiv;
            end
         end
         StDiv: begin
            if (!trial[32]) begin
               rem_d = trial[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = {rem_q[30:0], quo_q[31]};
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = StCalc;
         end
         StCalc: begin
            out_din_d = angle;
            state_d   = StWrite;
         end
         StWrite: begin
            if (!out_full) state_d = StRead;
         end
         default: state_d = StRead;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StRead;
         y_neg_q   <= 1'b0;
         x_neg_q   <= 1'b0;
         num_neg_q <= 1'b0;
         den_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         out_din_q <= '0;
      end else begin
         state_q   <= state_d;
         y_neg_q   <= y_neg_d;
         x_neg_q   <= x_neg_d;
         num_neg_q <= num_neg_d;
         den_q     <= den_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         out_din_q <= out_din_d;
      end
   end

endmodule

// File: tb/tb_qarctan_two_input.sv
// Bench for qarctan_two_input: FIFO models around the DUT, directed vectors, backpressure,
// a random stream scored against a C-style qarctan model, and a mid-division reset.
module tb_qarctan_two_input;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        inA_rd_en, inB_rd_en, out_wr_en;
   logic        inA_empty = 1'b1, inB_empty = 1'b1, out_full = 1'b0;
   logic [31:0] inA_dout = '0, inB_dout = '0, out_din;

   qarctan_two_input dut (
      .clock     (clock),
      .reset     (reset),
      .inA_rd_en (inA_rd_en),
      .inA_empty (inA_empty),
      .inA_dout  (inA_dout),
      .inB_rd_en (inB_rd_en),
      .inB_empty (inB_empty),
      .inB_dout  (inB_dout),
      .out_wr_en (out_wr_en),
      .out_full  (out_full),
      .out_din   (out_din)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0, pops = 0, writes = 0, last_pop = -1;
   bit chk_lat = 0, rnd_empty = 0, empty_force = 0;
   int full_mode = 2;  // 0 random, 1 held full, 2 never full
   int qa[$], qb[$], exp_q[$];

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qarctan(input int y, input int x);
      int ay, num, den, r, d, angle;
      ay = (y < 0 ? -y : y) + 1;
      if (x >= 0) begin
         num = (x - ay) * 1024;
         den = x + ay;
      end else begin
         num = (x + ay) * 1024;
         den = ay - x;
      end
      r     = num / den;
      d     = (804 * r) / 1024;
      angle = (x >= 0 ? 804 : 2412) - d;
      if (y < 0) angle = -angle;
      return angle;
   endfunction

   task automatic push_pair(input int y, input int x, input int exp);
      qa.push_back(y);
      qb.push_back(x);
      exp_q.push_back(exp);
   endtask

   task automatic drive();
      inA_empty = empty_force || (qa.size() == 0) || (rnd_empty && $urandom_range(0, 3) == 0);
      inB_empty = empty_force || (qb.size() == 0) || (rnd_empty && $urandom_range(0, 3) == 0);
      inA_dout  = (qa.size() != 0) ? qa[0] : 32'd0;
      inB_dout  = (qb.size() != 0) ? qb[0] : 32'd0;
      case (full_mode)
         0:       out_full = ($urandom_range(0, 3) == 0);
         1:       out_full = 1'b1;
         default: out_full = 1'b0;
      endcase
   endtask

   task automatic observe();
      check("proto", {inA_rd_en & inA_empty, inB_rd_en & inB_empty,
                      inA_rd_en ^ inB_rd_en, out_wr_en & out_full}, 0);
      if (out_wr_en) begin
         if (exp_q.size() == 0) check("spurious_write", 1, 0);
         else check("out_din", $signed(out_din), exp_q.pop_front());
         if (chk_lat) check("latency", cyc - last_pop, 34);
         writes++;
      end
      if (inA_rd_en && inB_rd_en) begin
         if (chk_lat && last_pop >= 0) check("throughput", cyc - last_pop, 35);
         void'(qa.pop_front());
         void'(qb.pop_front());
         last_pop = cyc;
         pops++;
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
      drive();
      @(negedge clock);
      cyc++;
      observe();
   endtask

   task automatic wait_pop(input int budget);
      int start = pops;
      int n = 0;
      while (pops == start && n < budget) begin
         cycle();
         n++;
      end
      if (pops == start) check("pop_timeout", 0, 1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) cycle();
      check("reset_outputs", {out_wr_en, inA_rd_en, inB_rd_en, out_din}, 0);
      reset = 1'b1;
      cycle();

      // Directed vectors, no stalls: exact latency and throughput
      chk_lat = 1;
      push_pair(0, 1000, 3);
      push_pair(1000, 0, 1608);
      push_pair(-1000, 0, -1608);
      push_pair(0, -1000, 3213);
      push_pair(500, 500, 804);
      drain(400);
      chk_lat = 0;
      repeat (3) cycle();

      // Backpressure on the first result
      full_mode = 1;
      push_pair(0, 1000, 3);
      push_pair(500, 500, 804);
      wait_pop(10);
      repeat (33) cycle();
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("bp_hold", {out_wr_en, inA_rd_en, inB_rd_en, out_din}, 3);
      end
      full_mode = 2;
      cycle();
      check("bp_release_write", out_wr_en, 1);
      cycle();
      check("bp_next_pop", {inA_rd_en, inB_rd_en}, 3);
      drain(100);

      // Random stream with toggled empty/full
      rnd_empty = 1;
      full_mode = 0;
      for (int i = 0; i < 256; i++) begin
         int y, x;
         y = int'($urandom_range(0, 65534)) - 32767;
         x = int'($urandom_range(0, 65534)) - 32767;
         push_pair(y, x, qarctan(y, x));
      end
      drain(256 * 80);
      check("stream_inputs_left", qa.size() + qb.size(), 0);
      rnd_empty = 0;
      full_mode = 2;
      repeat (3) cycle();

      // Reset mid-division: pair is lost, no partial result
      push_pair(123, -456, qarctan(123, -456));
      wait_pop(10);
      repeat (10) cycle();
      reset = 1'b0;
      empty_force = 1;
      #1;
      check("rst_mid_outputs", {out_wr_en, inA_rd_en, inB_rd_en, out_din}, 0);
      repeat (pops - writes) void'(exp_q.pop_front());
      writes = pops;
      repeat (2) cycle();
      reset = 1'b1;
      repeat (40) cycle();
      check("rst_no_write", writes, pops);
      empty_force = 0;
      push_pair(-300, 700, qarctan(-300, 700));
      wait_pop(2);
      drain(60);
      check("pairs_written", writes, pops);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
